// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the memory arbiter and its neighbours.
//   arb_state_e : arbiter FSM encoding (IDLE=0, ACCESS=1, RESP=2)
//   MODE_*      : MemMode access-size encoding shared with mips and exmemory
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  localparam logic [1:0] MODE_WORD = 2'd0;
  localparam logic [1:0] MODE_HALF = 2'd1;
  localparam logic [1:0] MODE_BYTE = 2'd2;

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin chooser.
//   req0, req1  : pending requests
//   last        : index granted most recently
//   grant_valid : at least one request pending
//   grant_idx   : chosen port (the one that is not last when both request)
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant_valid,
  output logic grant_idx
);

  assign grant_valid = req0 | req1;
  assign grant_idx   = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single exmemory port between two bus masters.
// Each transaction runs IDLE -> ACCESS -> RESP; one-cycle ack in RESP.
//   clk, reset               : clock, synchronous active-high reset
//   req/we/mode/addr/wdata 0,1 : master request channels (held until ack)
//   ack0/ack1, rdata0/rdata1 : completion pulse and read data per master
//   mem_we/mem_mode/mem_addr/mem_wdata/mem_rdata : exmemory port
//   busy                     : transaction in flight (ACCESS or RESP)
//
// state  | meaning
// IDLE   | waiting; arbitrates and latches the granted command
// ACCESS | command on memory port, mem_we may be high
// RESP   | address held, read data sampled, ack pulsed
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [1:0]        mode0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [1:0]        mode1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_we,
  output logic [1:0]        mem_mode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  arb_state_e        state_q;
  logic              sel_q;
  logic              last_q;
  logic              we_q;
  logic [1:0]        mode_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              mem_we_q;
  logic              busy_q;
  logic              ack0_q;
  logic              ack1_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  logic grant_valid_d;
  logic grant_idx_d;

  rr_pick2 u_pick (
    .req0        (req0),
    .req1        (req1),
    .last        (last_q),
    .grant_valid (grant_valid_d),
    .grant_idx   (grant_idx_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      sel_q    <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      mode_q   <= MODE_WORD;
      addr_q   <= '0;
      wdata_q  <= '0;
      mem_we_q <= 1'b0;
      busy_q   <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      mem_we_q <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_valid_d) begin
            sel_q    <= grant_idx_d;
            last_q   <= grant_idx_d;
            we_q     <= grant_idx_d ? we1    : we0;
            mode_q   <= grant_idx_d ? mode1  : mode0;
            addr_q   <= grant_idx_d ? addr1  : addr0;
            wdata_q  <= grant_idx_d ? wdata1 : wdata0;
            mem_we_q <= grant_idx_d ? we1    : we0;
            busy_q   <= 1'b1;
            state_q  <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          ack0_q  <= ~sel_q;
          ack1_q  <= sel_q;
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          if (sel_q) rdata1_q <= mem_rdata;
          else       rdata0_q <= mem_rdata;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Memory read data only settles during RESP, so while ack is high the
  // requester sees mem_rdata directly; the register keeps the sampled value.
  assign rdata0    = ack0_q ? mem_rdata : rdata0_q;
  assign rdata1    = ack1_q ? mem_rdata : rdata1_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign mem_we    = mem_we_q;
  assign mem_mode  = mode_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single `exmemory` access port (memory plus memory-mapped switches/LEDs/display) between the `mips` core (port 0) and a secondary bus master (port 1, e.g. a boot loader or debug DMA). It serialises requests with a round-robin policy and drives exactly one memory transaction at a time. Each transaction runs IDLE→ACCESS→RESP. A one-cycle acknowledge returns the read data to the requester. The block sits between the masters and `exmemory` inside `top`.

## Interface
- `ADDR_W`, default 16: memory address width.
- `DATA_W`, default 32: data width.
- `clk` in 1: system clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `req0` / `req1` in 1: request from port 0 / port 1.
- `we0` / `we1` in 1: 1 = write, 0 = read.
- `mode0` / `mode1` in 2: access size, same encoding as `MemMode`.
- `addr0` / `addr1` in ADDR_W: byte address.
- `wdata0` / `wdata1` in DATA_W: write data.
- `ack0` / `ack1` out 1: one-cycle completion pulse.
- `rdata0` / `rdata1` out DATA_W: read data, valid only while the matching ack is high.
- `mem_we` out 1: to `exmemory` MemWrite.
- `mem_mode` out 2: to `exmemory` MemMode.
- `mem_addr` out ADDR_W: to `exmemory` address.
- `mem_wdata` out DATA_W: to `exmemory` write data.
- `mem_rdata` in DATA_W: from `exmemory`.
- `busy` out 1: high in ACCESS or RESP.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**, no request pending: stay in IDLE.
- **IDLE**, one request pending: grant that port.
- **IDLE**, both requests pending: grant the port that is not `last` (the last-granted index).
- On a grant:
  - latch `sel`, `we`, `mode`, `addr` and `wdata` of the granted port into command registers;
  - set `last` = `sel`;
  - go to ACCESS.
- **ACCESS**:
  - drive `mem_addr`, `mem_mode` and `mem_wdata` from the command registers;
  - `mem_we` = latched `we` (this is the only state where `mem_we` can be 1);
  - go to RESP.
- **RESP**:
  - keep `mem_addr` and `mem_mode` unchanged, `mem_we` = 0;
  - sample `mem_rdata` into `rdata[sel]`;
  - pulse `ack[sel]` = 1 (other ack stays 0);
  - go to IDLE.
- Writes also produce an ack. `rdata` on a write ack is don't-care but must be driven (the sampled value).
- Requester protocol:
  - hold `req`, `we`, `mode`, `addr` and `wdata` stable from assertion until the ack;
  - drop `req`, or present the next request, starting the cycle after the ack.
- A request withdrawn before its ack:
  - before grant: it is simply not granted;
  - after grant: the latched transaction still completes and still acks.
- Fairness: under continuous contention, grants strictly alternate 0,1,0,1. No port waits more than one transaction.
- `last` resets to 1, so port 0 (CPU) wins the first contention.
- Reset in any state: FSM → IDLE, `last` → 1, command registers → 0, and the in-flight transaction is dropped with no ack.

## Timing
- Reset values:
  - `ack0` = `ack1` = 0, `busy` = 0;
  - `mem_we` = 0, `mem_mode` = 0, `mem_addr` = 0, `mem_wdata` = 0;
  - `rdata0` = `rdata1` = 0.
- All outputs are registered or decoded from state/command registers only. There are no combinational paths from the request inputs to the outputs.
- Latency: a request seen in IDLE at edge N gives ACCESS during cycle N+1, RESP/ack during N+2, and IDLE at N+3.
- Throughput: one transaction per 3 cycles.
- `exmemory` timing: it captures writes on the rising edge that ends ACCESS. Read data must be valid by the end of the RESP cycle (address held through RESP).
- Simultaneous `req0`/`req1` in IDLE: resolved by `last` in that cycle, with no extra latency.
- `mem_we` pulses for exactly one cycle per write. No back-to-back writes are possible, because IDLE separates transactions.

## Structure
- Shared package/header `mem_arb_pkg`:
  - state encoding (IDLE=0, ACCESS=1, RESP=2);
  - MemMode constants (MODE_WORD, MODE_HALF, MODE_BYTE), shared with `mips` and `exmemory`.
- One natural sub-module, `rr_pick2`: a two-way round-robin chooser (inputs `req0`, `req1`, `last`; outputs `grant_valid`, `grant_idx`).
- The FSM, command registers and rdata/ack registers stay in `mem_arbiter`.
- `top` instantiates `mem_arbiter` between `mips`, the second master and `exmemory`. `mips` stalls until `ack0`.

## Test plan
- Reset mid-ACCESS of a write from port 1 (`addr1` = 0x0040): `ack1` never pulses, `mem_we` = 0 the next cycle, FSM is IDLE, all outputs are 0.
- Port 0 alone, write word 0xDEADBEEF to 0x0010, then read 0x0010: `mem_we` is high for exactly one cycle; `ack0` arrives 2 cycles after each grant; the read gives `rdata0` = 0xDEADBEEF.
- Both ports request reads from reset (`addr0` = 0x0000, `addr1` = 0x0004): port 0 acks first, port 1 acks 3 cycles later, and the data matches memory contents.
- Continuous contention for 12 transactions: ack order is 0,1,0,1,…; each port gets 6 acks and neither waits more than 6 cycles.
- Port 1 drops `req1` the cycle after its grant: the transaction completes and `ack1` still pulses once. Port 1 with `req1` dropped before any grant is never acked.
- Read of the switches address with `switches` = 0x0004: `rdata0` = 0x00000004. Write 0x00A5 to the LED address: `leds` = 0x00A5 after the ack.
